// File: rtl/rf_array_pkg.sv
// rtl/rf_array_pkg.sv - shared sizes and select-decode helpers for the integer register file
package rf_array_pkg;

    localparam int RF_NREGS = 32;
    localparam int RF_SEL_W = 10;
    localparam int RF_WEN_W = 31;

    typedef struct packed {
        logic       ok;
        logic [2:0] idx;
    } rf_oh_dec_t;

    // One-hot-to-binary for the low select byte; ok is clear unless exactly one bit is set.
    function automatic rf_oh_dec_t rf_oh_dec(input logic [7:0] oh);
        rf_oh_dec_t d;
        d     = '0;
        d.ok  = (oh != 8'd0) && ((oh & (oh - 8'd1)) == 8'd0);
        for (int k = 0; k < 8; k++) begin
            if (oh[k]) begin
                d.idx = 3'(k);
            end
        end
        return d;
    endfunction

    // True when the write-enable vector has zero or one bit set.
    function automatic logic rf_wen_ok(input logic [RF_WEN_W:1] wen);
        return (wen & (wen - RF_WEN_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/rf_rd_port.sv
// rtl/rf_rd_port.sv - one S-stage read port with write-to-read bypass
//
// sel      : pre-decoded select, [7:0] one-hot of addr[2:0], [8]=addr[3], [9]=addr[4]
// rf_q     : register array r1..r31
// wen      : W-stage write enables, bit i targets register i
// wdata    : W-stage write data
// rd_data  : bypassed combinational read value
// sel_err  : low select byte was not exactly one-hot
module rf_rd_port
    import rf_array_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [RF_SEL_W-1:0] sel,
    input  logic [DATA_W-1:0]   rf_q [1:RF_NREGS-1],
    input  logic [RF_WEN_W:1]   wen,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rd_data,
    output logic                sel_err
);

    rf_oh_dec_t dec;
    logic [4:0] idx;
    logic       wen_ok;

    always_comb begin
        dec     = rf_oh_dec(sel[7:0]);
        idx     = {sel[9:8], dec.idx};
        wen_ok  = rf_wen_ok(wen);
        sel_err = !dec.ok;
        rd_data = '0;
        // r0 and malformed selects read as zero; a multi-hot write never bypasses.
        if (dec.ok && (idx != 5'd0)) begin
            if (wen_ok && wen[idx]) begin
                rd_data = wdata;
            end else begin
                rd_data = rf_q[idx];
            end
        end
    end

endmodule

// File: rtl/rf_array.sv
// rtl/rf_array.sv - 31-entry integer register file with bypassed dual read into E stage
//
// SYSCLK        : core clock
// RESET_D1_R_N  : asynchronous active-low reset
// CLMI_RHOLD    : pipeline hold, freezes all state
// READA_S/B_S   : pre-decoded read selects
// WRITEC_W_R    : one-hot write enable, bit i writes r<i>
// WRDATA_W      : write data
// REGADATA_E_R  : port A operand in E
// REGBDATA_E_R  : port B operand in E
// RF_SEL_ERR_R  : sticky illegal-encoding flag
module rf_array
    import rf_array_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                SYSCLK,
    input  logic                RESET_D1_R_N,
    input  logic                CLMI_RHOLD,
    input  logic [RF_SEL_W-1:0] READA_S,
    input  logic [RF_SEL_W-1:0] READB_S,
    input  logic [RF_WEN_W:1]   WRITEC_W_R,
    input  logic [DATA_W-1:0]   WRDATA_W,
    output logic [DATA_W-1:0]   REGADATA_E_R,
    output logic [DATA_W-1:0]   REGBDATA_E_R,
    output logic                RF_SEL_ERR_R
);

    logic [DATA_W-1:0] rf_q [1:RF_NREGS-1];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              err_a;
    logic              err_b;
    logic              wen_ok;

    assign wen_ok = rf_wen_ok(WRITEC_W_R);

    rf_rd_port #(.DATA_W(DATA_W)) u_port_a (
        .sel     (READA_S),
        .rf_q    (rf_q),
        .wen     (WRITEC_W_R),
        .wdata   (WRDATA_W),
        .rd_data (rd_a),
        .sel_err (err_a)
    );

    rf_rd_port #(.DATA_W(DATA_W)) u_port_b (
        .sel     (READB_S),
        .rf_q    (rf_q),
        .wen     (WRITEC_W_R),
        .wdata   (WRDATA_W),
        .rd_data (rd_b),
        .sel_err (err_b)
    );

    always_ff @(posedge SYSCLK or negedge RESET_D1_R_N) begin
        if (!RESET_D1_R_N) begin
            for (int i = 1; i < RF_NREGS; i++) begin
                rf_q[i] <= '0;
            end
            REGADATA_E_R <= '0;
            REGBDATA_E_R <= '0;
            RF_SEL_ERR_R <= 1'b0;
        end else if (!CLMI_RHOLD) begin
            if (wen_ok) begin
                for (int i = 1; i < RF_NREGS; i++) begin
                    if (WRITEC_W_R[i]) begin
                        rf_q[i] <= WRDATA_W;
                    end
                end
            end
            REGADATA_E_R <= rd_a;
            REGBDATA_E_R <= rd_b;
            if (err_a || err_b || !wen_ok) begin
                RF_SEL_ERR_R <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_array.sv
// tb/tb_rf_array.sv - directed scoreboard bench for rf_array
module tb_rf_array;

    logic        SYSCLK;
    logic        RESET_D1_R_N;
    logic        CLMI_RHOLD;
    logic [9:0]  READA_S;
    logic [9:0]  READB_S;
    logic [31:1] WRITEC_W_R;
    logic [31:0] WRDATA_W;
    logic [31:0] REGADATA_E_R;
    logic [31:0] REGBDATA_E_R;
    logic        RF_SEL_ERR_R;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        err;
        string       tag;
    } exp_t;

    exp_t scb [$];

    rf_array #(.DATA_W(32)) dut (
        .SYSCLK       (SYSCLK),
        .RESET_D1_R_N (RESET_D1_R_N),
        .CLMI_RHOLD   (CLMI_RHOLD),
        .READA_S      (READA_S),
        .READB_S      (READB_S),
        .WRITEC_W_R   (WRITEC_W_R),
        .WRDATA_W     (WRDATA_W),
        .REGADATA_E_R (REGADATA_E_R),
        .REGBDATA_E_R (REGBDATA_E_R),
        .RF_SEL_ERR_R (RF_SEL_ERR_R)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    function automatic logic [9:0] sel_of(input int r);
        logic [4:0] a;
        logic [9:0] s;
        a       = 5'(r);
        s       = '0;
        s[9]    = a[4];
        s[8]    = a[3];
        s[7:0]  = 8'd1 << a[2:0];
        return s;
    endfunction

    function automatic logic [31:1] wen_of(input int r);
        logic [31:1] w;
        w = '0;
        w[r] = 1'b1;
        return w;
    endfunction

    function automatic logic [31:0] pat(input int r);
        return 32'hC0DE0000 + 32'(r) * 32'h00010001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [9:0] sa, input logic [9:0] sb, input logic [31:1] wen,
                        input logic [31:0] wd, input logic hold, input logic [31:0] ea,
                        input logic [31:0] eb, input logic eerr, input string tag);
        exp_t e;
        READA_S    = sa;
        READB_S    = sb;
        WRITEC_W_R = wen;
        WRDATA_W   = wd;
        CLMI_RHOLD = hold;
        e.a = ea; e.b = eb; e.err = eerr; e.tag = tag;
        scb.push_back(e);
        @(posedge SYSCLK);
        #1;
        e = scb.pop_front();
        chk({e.tag, "_a"}, REGADATA_E_R, e.a);
        chk({e.tag, "_b"}, REGBDATA_E_R, e.b);
        chk({e.tag, "_err"}, {31'd0, RF_SEL_ERR_R}, {31'd0, e.err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_D1_R_N = 1'b0;
        CLMI_RHOLD   = 1'b0;
        READA_S      = sel_of(0);
        READB_S      = sel_of(0);
        WRITEC_W_R   = '0;
        WRDATA_W     = '0;
        #2;
        chk("rst_a", REGADATA_E_R, 32'd0);
        chk("rst_b", REGBDATA_E_R, 32'd0);
        chk("rst_err", {31'd0, RF_SEL_ERR_R}, 32'd0);
        @(posedge SYSCLK);
        #1;
        RESET_D1_R_N = 1'b1;

        // Fill every register while reading it back on both ports through the bypass.
        for (int i = 1; i < 32; i++) begin
            step(sel_of(i), sel_of(i), wen_of(i), pat(i), 1'b0, pat(i), pat(i), 1'b0, "fill_byp");
        end
        for (int i = 1; i < 32; i++) begin
            step(sel_of(i), sel_of(32 - i), '0, 32'hBAD0BAD0, 1'b0, pat(i), pat(32 - i), 1'b0, "readback");
        end

        step(sel_of(0), sel_of(0), wen_of(5), 32'hDEADBEEF, 1'b0, 32'd0, 32'd0, 1'b0, "wr_r5");
        step(10'b00_0010_0000, sel_of(0), '0, 32'd0, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, "rd_r5");

        step(10'b11_1000_0000, 10'b11_1000_0000, wen_of(31), 32'h12345678, 1'b0,
             32'h12345678, 32'h12345678, 1'b0, "byp_r31");

        step(sel_of(0), sel_of(31), '0, 32'hFFFF0000, 1'b0, 32'd0, 32'h12345678, 1'b0, "r0");
        step(sel_of(0), sel_of(0), wen_of(0 + 1) & '0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, "r0_both");

        step(sel_of(9), sel_of(9), wen_of(9), 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, "pre_hold");
        for (int i = 0; i < 3; i++) begin
            step(sel_of(7), sel_of(5), wen_of(7), 32'h00000001, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, "hold");
        end
        step(sel_of(7), sel_of(7), '0, 32'd0, 1'b0, pat(7), pat(7), 1'b0, "post_hold_r7");

        step(sel_of(3), sel_of(4), wen_of(3) | wen_of(4), 32'hFFFFFFFF, 1'b0, pat(3), pat(4), 1'b1, "multi_wen");
        step(sel_of(3), sel_of(4), '0, 32'd0, 1'b0, pat(3), pat(4), 1'b1, "multi_wen_rd");
        step(sel_of(5), 10'b00_0000_0011, '0, 32'd0, 1'b0, 32'hDEADBEEF, 32'd0, 1'b1, "bad_selb");
        step(sel_of(9), sel_of(31), '0, 32'd0, 1'b0, 32'hA5A5A5A5, 32'h12345678, 1'b1, "err_sticky");

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2;
        RESET_D1_R_N = 1'b0;
        #1;
        chk("async_rst_a", REGADATA_E_R, 32'd0);
        chk("async_rst_b", REGBDATA_E_R, 32'd0);
        chk("async_rst_err", {31'd0, RF_SEL_ERR_R}, 32'd0);
        @(posedge SYSCLK);
        #1;
        RESET_D1_R_N = 1'b1;
        step(sel_of(5), sel_of(31), '0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
